dcache_write_buffer: RTL and testbench
======================================

DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of posted-write entries (power of two, >=2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 c_req  input  1  SHALL indicate a data-cache request to memory, held stable while c_wait=1.
REQ-005 c_write  input  1  SHALL select write (1) or read (0) for c_req.
REQ-006 c_addr  input  32  SHALL carry the request address.
REQ-007 c_in  input  32  SHALL carry write data.
REQ-008 c_type  input  3  SHALL carry the access type (byte/half/word encoding, passed through unchanged).
REQ-009 c_out  output  32  SHALL return read data.
REQ-010 c_wait  output  1  SHALL stall the data cache.
REQ-011 m_read, m_write  output  1 each  SHALL request a read/write from the AXI master.
REQ-012 m_addr  output  32, m_din  output  32, m_type  output  3  SHALL carry the master-side address, write data and type.
REQ-013 m_dout  input  32  SHALL be master read data; m_stall  input  1  SHALL be master busy.
REQ-014 wb_empty  output  1, wb_full  output  1, wb_count  output  $clog2(DEPTH)+1  SHALL report occupancy.

Function
REQ-015 Entries SHALL hold {addr, data, type} in a circular FIFO with wrapping read/write pointers and a count register.
REQ-016 FSM states SHALL be IDLE, WRITE, READ, RESP.
REQ-017 Write accept: c_req & c_write & state in {IDLE, WRITE} & count<DEPTH at cycle start SHALL push the entry and drive c_wait=0 combinationally that cycle.
REQ-018 Write reject: c_req & c_write with count==DEPTH, or state in {READ, RESP}, SHALL drive c_wait=1; no push.
REQ-019 A full buffer SHALL NOT accept a push in the same cycle as a pop; the write is accepted the following cycle.
REQ-020 IDLE -> WRITE when count>0; m_write=1 in WRITE only, with m_addr/m_din/m_type from the head entry.
REQ-021 WRITE completes on the first cycle in WRITE with m_stall=0: pop head, go to IDLE; minimum one cycle in WRITE.
REQ-022 Simultaneous push and pop SHALL leave count unchanged.
REQ-023 Read ordering: c_req & ~c_write SHALL hold c_wait=1 until the buffer is empty; IDLE -> READ only when count==0 and no write pending, latching c_addr/c_type.
REQ-024 In READ, m_read=1 with latched address/type; on first cycle with m_stall=0, register m_dout into c_out and go to RESP.
REQ-025 RESP SHALL last exactly one cycle with c_wait=0, then return to IDLE.
REQ-026 c_wait SHALL be 1 for a read request in all states except RESP; c_wait=0 when c_req=0.
REQ-027 m_read and m_write SHALL never be 1 in the same cycle.
REQ-028 wb_empty=(count==0), wb_full=(count==DEPTH), wb_count=count.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, pointers=0, count=0, c_out=0, m_read=0, m_write=0, m_addr/m_din=0, m_type=0, wb_empty=1, wb_full=0; pending entries are discarded.
REQ-030 Reset asserted mid-WRITE or mid-READ SHALL drop m_write/m_read asynchronously, without waiting for m_stall.

Verification
REQ-031 Posted write: store addr 0x0001_0004, data 0xDEAD_BEEF, m_stall=0 -> c_wait=0 same cycle, m_write=1 next cycle with those values, count 1->0.
REQ-032 Full: 5 back-to-back writes, m_stall=1 held -> first 4 accepted, wb_full=1, 5th sees c_wait=1 until one cycle after the first pop.
REQ-033 Read after writes: 2 writes then read of 0x0001_0004, m_dout=0x1234_5678 -> both m_write complete before m_read rises; c_out=0x1234_5678 with c_wait=0 for exactly one cycle.
REQ-034 Wrap-around: 10 writes with distinct data, drained with m_stall=0 -> m_din order matches push order across pointer wrap.
REQ-035 Reset mid-WRITE: 3 entries, m_stall=1, assert rst -> m_write=0 immediately, wb_count=0, wb_empty=1; no writes issued after release.
REQ-036 Write during read: write request while in READ -> c_wait=1, no push until after RESP.

Source files
------------

// File: rtl/dcache_write_buffer_if.sv
// dcache_write_buffer_if
//   Bundles the data-cache side, the memory-master side and the occupancy
//   status of the posted-write buffer.
//
//   Cache side : c_req, c_write, c_addr, c_in, c_type -> buffer
//                c_out, c_wait                       <- buffer
//   Master side: m_read, m_write, m_addr, m_din, m_type <- buffer
//                m_dout, m_stall                       -> buffer
//   Status     : wb_empty, wb_full, wb_count           <- buffer
//
//   Handshakes: a cache request (c_req) completes in the cycle where
//   c_wait=0; the cache holds c_req and its payload stable while c_wait=1.
//   A master request (m_read/m_write) completes in the cycle where
//   m_stall=0; the buffer holds the request and payload stable until then.
//
//   modport slave  : the write buffer itself.
//   modport master : whatever drives the cache side and models the memory.
interface dcache_write_buffer_if #(
  parameter int DEPTH = 4
);
  logic                    c_req;
  logic                    c_write;
  logic [31:0]             c_addr;
  logic [31:0]             c_in;
  logic [2:0]              c_type;
  logic [31:0]             c_out;
  logic                    c_wait;
  logic                    m_read;
  logic                    m_write;
  logic [31:0]             m_addr;
  logic [31:0]             m_din;
  logic [2:0]              m_type;
  logic [31:0]             m_dout;
  logic                    m_stall;
  logic                    wb_empty;
  logic                    wb_full;
  logic [$clog2(DEPTH):0]  wb_count;

  modport slave (
    input  c_req, c_write, c_addr, c_in, c_type, m_dout, m_stall,
    output c_out, c_wait, m_read, m_write, m_addr, m_din, m_type,
           wb_empty, wb_full, wb_count
  );

  modport master (
    output c_req, c_write, c_addr, c_in, c_type, m_dout, m_stall,
    input  c_out, c_wait, m_read, m_write, m_addr, m_din, m_type,
           wb_empty, wb_full, wb_count
  );
endinterface

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//   Posted-write buffer between a data cache and an AXI-style memory master.
//   Writes are accepted into a DEPTH-entry circular FIFO without stalling
//   the cache (unless full) and drained one at a time to the master.
//   Reads are held off until every buffered write has drained, so a read
//   always observes earlier writes.
//
//   Ports:
//     clk       - single clock, rising edge
//     rst       - asynchronous, active-high reset
//     bus       - dcache_write_buffer_if.slave (cache side, master side,
//                 occupancy status)
//     dbg_state - current FSM state (IDLE=0, WRITE=1, READ=2, RESP=3)
module dcache_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  dcache_write_buffer_if.slave       bus,
  output logic [1:0]                 dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;

  logic [31:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [2:0]      type_mem [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     c_out_q;
  logic            m_read_q;
  logic            m_write_q;
  logic [31:0]     m_addr_q;
  logic [31:0]     m_din_q;
  logic [2:0]      m_type_q;

  logic            is_full;
  logic            is_empty;
  logic            push;
  logic            pop;
  logic            c_wait_c;

  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);

  // Fullness is judged on the count at the start of the cycle, so a full
  // buffer refuses a write even while it is popping; the write lands next
  // cycle instead.
  assign push = bus.c_req & bus.c_write & ~is_full &
                ((state == IDLE) || (state == WRITE));

  // The head entry retires on the first non-stalled WRITE cycle.
  assign pop  = (state == WRITE) & ~bus.m_stall;

  // Writes are released the same cycle they are pushed. Reads only see
  // c_wait=0 in RESP, when c_out holds the registered read data.
  always_comb begin
    c_wait_c = 1'b0;
    if (bus.c_req) begin
      if (bus.c_write) c_wait_c = ~push;
      else             c_wait_c = (state != RESP);
    end
  end

  // Payload storage needs no reset: entries are only read when counted.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.c_addr;
      data_mem[wr_ptr] <= bus.c_in;
      type_mem[wr_ptr] <= bus.c_type;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      c_out_q   <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_din_q   <= '0;
      m_type_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (!is_empty) begin
            state     <= WRITE;
            m_write_q <= 1'b1;
            m_addr_q  <= addr_mem[rd_ptr];
            m_din_q   <= data_mem[rd_ptr];
            m_type_q  <= type_mem[rd_ptr];
          end else if (push) begin
            // Empty buffer: the entry being pushed becomes the head, so its
            // payload is forwarded straight to the master next cycle.
            state     <= WRITE;
            m_write_q <= 1'b1;
            m_addr_q  <= bus.c_addr;
            m_din_q   <= bus.c_in;
            m_type_q  <= bus.c_type;
          end else if (bus.c_req && !bus.c_write) begin
            // Buffer empty and no write arriving: reads may now go out.
            state     <= READ;
            m_read_q  <= 1'b1;
            m_addr_q  <= bus.c_addr;
            m_type_q  <= bus.c_type;
          end
        end

        WRITE: begin
          if (!bus.m_stall) begin
            state     <= IDLE;
            m_write_q <= 1'b0;
          end
        end

        READ: begin
          if (!bus.m_stall) begin
            state    <= RESP;
            m_read_q <= 1'b0;
            c_out_q  <= bus.m_dout;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.c_out    = c_out_q;
  assign bus.c_wait   = c_wait_c;
  assign bus.m_read   = m_read_q;
  assign bus.m_write  = m_write_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_din    = m_din_q;
  assign bus.m_type   = m_type_q;
  assign bus.wb_empty = is_empty;
  assign bus.wb_full  = is_full;
  assign bus.wb_count = count;
  assign dbg_state    = state;

endmodule

// File: tb/tb_dcache_write_buffer.sv
module tb_dcache_write_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  dcache_write_buffer_if #(.DEPTH(DEPTH)) bus ();

  dcache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [66:0] exp_q[$];      // expected master writes {addr, data, type}
  logic [31:0] exp_rd_q[$];   // expected c_out for each read response
  int n_checks = 0;
  int n_fail   = 0;
  logic prev_m_read = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("no_rd_wr_overlap", 32'(bus.m_read & bus.m_write), 32'd0);
      if (bus.m_write && !bus.m_stall) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: m_addr %h m_din %h, required no write",
                   bus.m_addr, bus.m_din);
        end else begin
          logic [66:0] e;
          e = exp_q.pop_front();
          check("m_addr", bus.m_addr, e[66:35]);
          check("m_din", bus.m_din, e[34:3]);
          check("m_type", 32'(bus.m_type), 32'(e[2:0]));
        end
      end
      if (bus.m_read && !prev_m_read)
        check("writes_drained_before_read", 32'(exp_q.size()), 32'd0);
      if (bus.c_req && !bus.c_write && !bus.c_wait) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read_resp: c_out %h, required none", bus.c_out);
        end else begin
          check("c_out", bus.c_out, exp_rd_q.pop_front());
        end
      end
      prev_m_read = bus.m_read;
    end else begin
      prev_m_read = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] t, output int waits);
    exp_q.push_back({a, d, t});
    bus.c_req   = 1'b1;
    bus.c_write = 1'b1;
    bus.c_addr  = a;
    bus.c_in    = d;
    bus.c_type  = t;
    waits = 0;
    @(negedge clk);
    while (bus.c_wait && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (bus.c_wait) check("write_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.c_req   = 1'b0;
    bus.c_write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] t,
                         input logic [31:0] dout, output int waits);
    exp_rd_q.push_back(dout);
    bus.m_dout  = dout;
    bus.c_req   = 1'b1;
    bus.c_write = 1'b0;
    bus.c_addr  = a;
    bus.c_type  = t;
    waits = 0;
    @(negedge clk);
    while (bus.c_wait && waits < 60) begin
      waits++;
      @(negedge clk);
    end
    if (bus.c_wait) check("read_resp_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.c_req = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    @(negedge clk);
    while (!(bus.wb_empty && !bus.m_write && !bus.m_read) && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("drain_complete", 32'(bus.wb_empty && !bus.m_write), 32'd1);
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int w;
  logic seen_write;

  initial begin
    rst         = 1'b1;
    bus.c_req   = 1'b0;
    bus.c_write = 1'b0;
    bus.c_addr  = '0;
    bus.c_in    = '0;
    bus.c_type  = '0;
    bus.m_dout  = '0;
    bus.m_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wb_empty", 32'(bus.wb_empty), 32'd1);
    check("rst_wb_full", 32'(bus.wb_full), 32'd0);
    check("rst_wb_count", 32'(bus.wb_count), 32'd0);
    check("rst_m_write", 32'(bus.m_write), 32'd0);
    check("rst_m_read", 32'(bus.m_read), 32'd0);
    check("rst_c_out", bus.c_out, 32'd0);
    check("rst_c_wait_idle", 32'(bus.c_wait), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;

    // Posted write, released the same cycle, issued the next cycle
    bus.m_stall = 1'b0;
    exp_q.push_back({32'h0001_0004, 32'hDEAD_BEEF, 3'b010});
    bus.c_req = 1'b1; bus.c_write = 1'b1;
    bus.c_addr = 32'h0001_0004; bus.c_in = 32'hDEAD_BEEF; bus.c_type = 3'b010;
    @(negedge clk);
    check("posted_c_wait", 32'(bus.c_wait), 32'd0);
    check("posted_count_before", 32'(bus.wb_count), 32'd0);
    @(posedge clk);
    #1;
    bus.c_req = 1'b0; bus.c_write = 1'b0;
    @(negedge clk);
    check("posted_m_write", 32'(bus.m_write), 32'd1);
    check("posted_m_addr", bus.m_addr, 32'h0001_0004);
    check("posted_m_din", bus.m_din, 32'hDEAD_BEEF);
    check("posted_count_1", 32'(bus.wb_count), 32'd1);
    @(negedge clk);
    check("posted_m_write_done", 32'(bus.m_write), 32'd0);
    check("posted_count_0", 32'(bus.wb_count), 32'd0);
    wait_drain();

    // Full buffer: 4 accepted, 5th held until the cycle after the first pop
    @(posedge clk);
    #1;
    bus.m_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_write(32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 3'b010, w);
      check("full_accept_wait", 32'(w), 32'd0);
    end
    exp_q.push_back({32'h0000_1010, 32'hA000_0004, 3'b010});
    bus.c_req = 1'b1; bus.c_write = 1'b1;
    bus.c_addr = 32'h0000_1010; bus.c_in = 32'hA000_0004; bus.c_type = 3'b010;
    @(negedge clk);
    check("full_wb_full", 32'(bus.wb_full), 32'd1);
    check("full_wb_count", 32'(bus.wb_count), 32'd4);
    check("full_5th_wait_a", 32'(bus.c_wait), 32'd1);
    @(negedge clk);
    check("full_5th_wait_b", 32'(bus.c_wait), 32'd1);
    @(posedge clk);
    #1;
    bus.m_stall = 1'b0;
    @(negedge clk);
    check("full_5th_wait_pop_cycle", 32'(bus.c_wait), 32'd1);
    @(negedge clk);
    check("full_5th_accept_after_pop", 32'(bus.c_wait), 32'd0);
    check("full_count_after_pop", 32'(bus.wb_count), 32'd3);
    @(posedge clk);
    #1;
    bus.c_req = 1'b0; bus.c_write = 1'b0;
    wait_drain();

    // Read after two writes: writes drain first, one-cycle response
    @(posedge clk);
    #1;
    bus.m_stall = 1'b0;
    do_write(32'h0000_2000, 32'h1111_1111, 3'b010, w);
    check("raw_w1_wait", 32'(w), 32'd0);
    do_write(32'h0000_2004, 32'h2222_2222, 3'b001, w);
    check("raw_w2_wait", 32'(w), 32'd0);
    do_read(32'h0001_0004, 3'b010, 32'h1234_5678, w);
    check("raw_read_wait_cycles", 32'(w), 32'd4);
    @(negedge clk);
    check("raw_resp_one_cycle", 32'(dbg_state), 32'd0);
    check("raw_c_out_held", bus.c_out, 32'h1234_5678);

    // Wrap-around: 10 writes through a 4-entry ring
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++)
      do_write(32'h0000_3000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i * 17),
               3'(i % 3), w);
    wait_drain();

    // Reset while a write is stalled at the master
    @(posedge clk);
    #1;
    bus.m_stall = 1'b1;
    for (int i = 0; i < 3; i++)
      do_write(32'h0000_4000 + 32'(i * 4), 32'hBAD0_0000 + 32'(i), 3'b010, w);
    @(negedge clk);
    check("pre_rst_m_write", 32'(bus.m_write), 32'd1);
    check("pre_rst_count", 32'(bus.wb_count), 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_m_write", 32'(bus.m_write), 32'd0);
    check("async_rst_count", 32'(bus.wb_count), 32'd0);
    check("async_rst_empty", 32'(bus.wb_empty), 32'd1);
    check("async_rst_c_out", bus.c_out, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.m_stall = 1'b0;
    seen_write = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.m_write) seen_write = 1'b1;
    end
    check("no_write_after_rst", 32'(seen_write), 32'd0);

    // Write presented while a read is outstanding
    @(posedge clk);
    #1;
    bus.m_stall = 1'b1;
    exp_rd_q.push_back(32'hCAFE_F00D);
    bus.m_dout = 32'hCAFE_F00D;
    bus.c_req = 1'b1; bus.c_write = 1'b0;
    bus.c_addr = 32'h0000_5000; bus.c_type = 3'b010;
    @(negedge clk);
    check("wdr_read_wait", 32'(bus.c_wait), 32'd1);
    @(posedge clk);
    #1;
    bus.c_write = 1'b1; bus.c_addr = 32'h0000_6000; bus.c_in = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wdr_in_read", 32'(dbg_state), 32'd2);
      check("wdr_write_wait", 32'(bus.c_wait), 32'd1);
      check("wdr_no_push", 32'(bus.wb_count), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.c_write = 1'b0; bus.c_addr = 32'h0000_5000;
    bus.m_stall = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wdr_resp", 32'(bus.c_wait), 32'd0);
    @(posedge clk);
    #1;
    bus.c_req = 1'b0;
    do_write(32'h0000_6000, 32'h5555_AAAA, 3'b010, w);
    check("wdr_write_after_resp", 32'(w), 32'd0);
    wait_drain();
    check("all_reads_seen", 32'(exp_rd_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
